// File: rtl/master_bus_bridge.sv
// Bridges frames from a UART receiver to a bus master port through a small command FIFO.
// Read transactions return one byte to the UART transmitter.
module master_bus_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0]   uart_register_in,
    input  logic                             valid_in,
    output logic [DATA_WIDTH-1:0]            uart_register_out,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    output logic [DATA_WIDTH-1:0]            m_wr_data,
    output logic                             m_mode,
    output logic                             m_start,
    input  logic                             m_done,
    input  logic [DATA_WIDTH-1:0]            m_rd_data,
    output logic                             overflow,
    output logic                             timeout_err
);
    // state     | meaning
    // IDLE      | waiting for a queued command
    // ISSUE     | m_start pulse, timeout counter loaded
    // WAIT      | waiting for m_done or timeout
    // RESP      | waiting for ready_out to send read byte
    // RESP_WAIT | waiting for transmitter busy->ready
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT      = 3'd2;
    localparam logic [2:0] RESP      = 3'd3;
    localparam logic [2:0] RESP_WAIT = 3'd4;

    localparam int FW   = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int TW   = $clog2(TIMEOUT);

    logic [FW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CNTW-1:0]       count;
    logic                  empty, full, push, pop;

    logic [2:0]            state;
    logic [FW-1:0]         cmd;
    logic [DATA_WIDTH-1:0] resp;
    logic [TW-1:0]         timer;
    logic                  seen_busy;

    assign empty = (count == '0);
    assign full  = (count == CNTW'(FIFO_DEPTH));
    assign pop   = (state == IDLE) && !empty;
    // A full FIFO still accepts a frame in the same cycle its head is popped.
    assign push  = valid_in && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_register_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CNTW'(1);
            else if (pop && !push) count <= count - CNTW'(1);
            if (valid_in && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cmd         <= '0;
            resp        <= '0;
            timer       <= '0;
            seen_busy   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd   <= mem[rd_ptr];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= TW'(TIMEOUT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        if (cmd[FW-1]) begin
                            state <= IDLE;
                        end else begin
                            resp  <= m_rd_data;
                            state <= RESP;
                        end
                    end else if (timer == '0) begin
                        timeout_err <= 1'b1;
                        if (cmd[FW-1]) begin
                            state <= IDLE;
                        end else begin
                            resp  <= '1;
                            state <= RESP;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RESP: begin
                    if (ready_out) begin
                        seen_busy <= 1'b0;
                        state     <= RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    if (!ready_out)     seen_busy <= 1'b1;
                    else if (seen_busy) state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_start           = (state == ISSUE);
    assign valid_out         = (state == RESP) && ready_out;
    assign m_mode            = cmd[FW-1];
    assign m_addr            = cmd[FW-2:DATA_WIDTH];
    assign m_wr_data         = cmd[DATA_WIDTH-1:0];
    assign uart_register_out = resp;
endmodule

// File: doc/master_bus_bridge.md
MASTER_BUS_BRIDGE -- requirements
Module: master_bus_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, giving the bus address bits carried per frame.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the data byte width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), giving the command FIFO entries.
REQ-004 The block SHALL have parameter TIMEOUT, default 4096, giving the cycles to wait for master completion.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  input  1  system clock, all state on rising edge.
REQ-007 Port: rstn  input  1  asynchronous active-low reset.
REQ-008 Port: uart_register_in  input  1+ADDR_WIDTH+DATA_WIDTH (25)  received frame: [24]=write flag, [23:8]=address, [7:0]=write data.
REQ-009 Port: valid_in  input  1  one-cycle pulse, frame valid from uart_rx.
REQ-010 Port: uart_register_out  output  DATA_WIDTH  read-response byte to uart_tx.
REQ-011 Port: valid_out  output  1  one-cycle pulse requesting uart_tx send.
REQ-012 Port: ready_out  input  1  uart_tx idle/ready.
REQ-013 Port: m_addr  output  ADDR_WIDTH  transaction address to master_port.
REQ-014 Port: m_wr_data  output  DATA_WIDTH  write data to master_port.
REQ-015 Port: m_mode  output  1  1=write, 0=read.
REQ-016 Port: m_start  output  1  one-cycle transaction start pulse.
REQ-017 Port: m_done  input  1  one-cycle pulse, master transaction finished.
REQ-018 Port: m_rd_data  input  DATA_WIDTH  read data, valid in the m_done cycle.
REQ-019 Port: overflow  output  1  sticky: a frame was dropped on full FIFO.
REQ-020 Port: timeout_err  output  1  sticky: a transaction timed out.

Function
REQ-021 Each valid_in pulse SHALL push uart_register_in into the FIFO in the same edge if not full; if full, the frame is dropped and overflow set.
REQ-022 Simultaneous push and pop SHALL be accepted when full or empty without loss; pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP, RESP_WAIT.
REQ-024 IDLE: FIFO non-empty -> pop head into command register, go ISSUE next cycle.
REQ-025 ISSUE: drive m_start=1 for exactly one cycle with m_addr/m_wr_data/m_mode from command register; go WAIT; clear timeout counter.
REQ-026 m_addr, m_wr_data, m_mode SHALL hold stable from ISSUE until leaving WAIT.
REQ-027 WAIT: m_done=1 -> write: go IDLE; read: capture m_rd_data, go RESP.
REQ-028 WAIT: counter reaches TIMEOUT-1 without m_done -> set timeout_err; write: go IDLE; read: capture 8'hFF, go RESP.
REQ-029 m_done outside WAIT SHALL be ignored.
REQ-030 RESP: when ready_out=1 pulse valid_out one cycle with captured byte on uart_register_out, go RESP_WAIT; else stay.
REQ-031 RESP_WAIT: wait for ready_out=0 then ready_out=1 (send complete), go IDLE; uart_register_out holds until then.
REQ-032 Latency: frame pushed into empty FIFO while IDLE -> m_start asserted 2 cycles after valid_in.
REQ-033 Commands SHALL be issued strictly in arrival order; one outstanding transaction max.

Reset
REQ-034 rstn low SHALL immediately force FSM IDLE, FIFO empty, m_start=0, valid_out=0, m_addr=0, m_wr_data=0, m_mode=0, uart_register_out=0, overflow=0, timeout_err=0, counter=0.
REQ-035 Reset mid-transaction SHALL abandon it; no m_start or valid_out until a new frame arrives after release.

Verification
REQ-036 Write: frame {1,16'h0812,8'hA5}; m_done 5 cycles after m_start -> m_start 2 cycles after valid_in, m_addr=0x0812, m_wr_data=0xA5, m_mode=1, no valid_out.
REQ-037 Read: frame {0,16'h1004,8'h00}; m_done with m_rd_data=0x3C -> valid_out pulse, uart_register_out=0x3C once ready_out=1.
REQ-038 Overflow: 5 back-to-back frames with m_done held low, FIFO_DEPTH=4 -> first 4 queued (1 issued, 3 stored... 5th accepted only if slot freed), overflow=1 on first dropped frame, order preserved.
REQ-039 Timeout: read frame, m_done never -> after TIMEOUT cycles timeout_err=1, uart_register_out=0xFF, valid_out pulse.
REQ-040 Backpressure: read completes with ready_out=0 for 20 cycles -> valid_out held off, fires in first cycle ready_out=1.
REQ-041 Reset in WAIT: rstn low during read -> all outputs zero, FIFO empty; after release no stray valid_out.
